// File: rtl/cascade_stage_sequencer.sv
// Viola-Jones cascade walker: stage/feature sequencing, saturating vote sum, verdict.
// Define CASCADE_PERF_EN to build the feat_count performance counter.
module cascade_stage_sequencer #(
  parameter int NUM_STAGES = 22,
  parameter int ACC_W      = 32,
  parameter int GIDX_W     = 12
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    start,
  output int                      stage_num,
  input  int                      feat_amount,
  input  logic signed [ACC_W-1:0] stage_thresh,
  output logic                    feat_req,
  output logic [GIDX_W-1:0]       feat_gidx,
  input  logic                    feat_valid,
  input  logic signed [ACC_W-1:0] feat_value,
  output logic                    busy,
  output logic                    done,
  output logic                    face,
  output logic                    err,
  output logic [GIDX_W-1:0]       feat_count
);

  typedef enum logic [2:0] {
    IDLE, LOAD, ISSUE, WAIT, COMPARE, DONE
  } state_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN =
    {1'b1, {(ACC_W-1){1'b0}}};

  state_t                  state;
  int                      amt_q;
  int                      idx;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W:0]   sum;
  logic signed [ACC_W-1:0] acc_sat;

  // One extra bit exposes signed overflow; clamp instead of wrapping.
  always_comb begin
    sum = {acc[ACC_W-1], acc}
        + {feat_value[ACC_W-1], feat_value};
    if (sum[ACC_W] != sum[ACC_W-1])
      acc_sat = sum[ACC_W] ? ACC_MIN : ACC_MAX;
    else
      acc_sat = sum[ACC_W-1:0];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      stage_num <= 0;
      amt_q     <= 0;
      idx       <= 0;
      acc       <= '0;
      feat_req  <= 1'b0;
      feat_gidx <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      face      <= 1'b0;
      err       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD;
            busy      <= 1'b1;
            stage_num <= 0;
            feat_gidx <= '0;
            acc       <= '0;
          end
        end
        LOAD: begin
          amt_q <= feat_amount;
          if (feat_amount <= 0) begin
            state <= DONE;
            done  <= 1'b1;
            err   <= 1'b1;
            face  <= 1'b0;
          end else begin
            idx      <= 0;
            acc      <= '0;
            feat_req <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          feat_req <= 1'b0;
          state    <= WAIT;
        end
        WAIT: begin
          if (feat_valid) begin
            acc       <= acc_sat;
            feat_gidx <= feat_gidx + GIDX_W'(1);
            if (idx == amt_q - 1) begin
              state <= COMPARE;
            end else begin
              idx      <= idx + 1;
              feat_req <= 1'b1;
              state    <= ISSUE;
            end
          end
        end
        COMPARE: begin
          if (acc < stage_thresh) begin
            state <= DONE;
            done  <= 1'b1;
            face  <= 1'b0;
            err   <= 1'b0;
          end else if (stage_num == NUM_STAGES - 1) begin
            state <= DONE;
            done  <= 1'b1;
            face  <= 1'b1;
            err   <= 1'b0;
          end else begin
            stage_num <= stage_num + 1;
            state     <= LOAD;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CASCADE_PERF_EN
  always_ff @(posedge Clk) begin
    if (Reset)
      feat_count <= '0;
    else if (state == IDLE && start)
      feat_count <= '0;
    else if (state == WAIT && feat_valid &&
             feat_count != '1)
      feat_count <= feat_count + GIDX_W'(1);
  end
`else
  assign feat_count = '0;
`endif

endmodule

// File: doc/cascade_stage_sequencer.md
Name: cascade_stage_sequencer

Overview:
- Drives the Viola-Jones cascade for one candidate window: walks stages 0..NUM_STAGES-1 and, within each stage, the feature indices 0..feat_amount-1.
- Sits directly downstream of the per-stage feature-count lookup. It drives `stage_num` into that lookup and consumes `feat_amount` back.
- Requests each weak-classifier result from the feature evaluator, accumulates the results, and compares the sum against the stage threshold.
- Reports face / no-face for the window, with early rejection on the first failing stage.

Parameters:
- NUM_STAGES, 22, number of cascade stages.
- ACC_W, 32, signed width of the stage accumulator, `feat_value` and `stage_thresh`.
- GIDX_W, 12, width of the global feature index. The total feature count is 2135.

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- start  in  1  window ready; sampled only in IDLE
- stage_num  out  int  current stage, feeds the feature-count lookup
- feat_amount  in  int  feature count for `stage_num`; -1 means invalid
- stage_thresh  in  ACC_W  signed threshold for `stage_num`; combinational from the threshold ROM
- feat_req  out  1  one-cycle request to the evaluator
- feat_gidx  out  GIDX_W  global feature index for the request
- feat_valid  in  1  evaluator result strobe
- feat_value  in  ACC_W  signed weak-classifier vote
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the verdict is ready
- face  out  1  verdict; held until the next `done`
- err  out  1  high together with `done` when an invalid `feat_amount` is seen; held until the next `done`
- feat_count  out  GIDX_W  performance counter (see Optional Feature)

Behaviour:
- Reset: all outputs go to 0, `stage_num` = 0, state = IDLE. Accumulator, local index and `feat_gidx` clear. Reset asserted in any state aborts the window with no `done`.
- States: IDLE, LOAD, ISSUE, WAIT, COMPARE, DONE.
- IDLE:
  - `start` = 1 -> LOAD, with `stage_num` = 0, `feat_gidx` = 0, accumulator = 0.
  - `start` is ignored in every other state.
- LOAD (1 cycle):
  - Register `feat_amount` into `amt_q`.
  - If `feat_amount` <= 0 -> DONE with `err` = 1, `face` = 0.
  - Otherwise clear the local index and the accumulator -> ISSUE.
- ISSUE (1 cycle): `feat_req` = 1 with the current `feat_gidx` -> WAIT.
- WAIT:
  - Hold until `feat_valid`.
  - On `feat_valid`: `acc <= sat(acc + feat_value)`, where saturation clamps to the signed ACC_W min/max and never wraps. Increment `feat_gidx`.
  - If local index == `amt_q`-1 -> COMPARE. Otherwise increment the local index -> ISSUE.
  - `feat_valid` outside WAIT is ignored.
- Latency per feature: minimum 2 cycles (ISSUE + WAIT with a same-cycle `feat_valid`). Back-to-back `feat_req` pulses are at least 2 cycles apart.
- COMPARE (1 cycle), signed compare `acc >= stage_thresh`:
  - Fail -> DONE, `face` = 0. The early exit leaves the remaining stages unevaluated.
  - Pass with `stage_num` == NUM_STAGES-1 -> DONE, `face` = 1.
  - Pass otherwise -> `stage_num` + 1 -> LOAD.
  - `feat_gidx` continues across stages, so it equals the running sum of the previous stages' counts.
- DONE (1 cycle): `done` = 1 -> IDLE. `face` and `err` hold their values afterwards. `stage_num` holds the last evaluated stage until the next `start`.
- `busy` = 1 in every state except IDLE.

Optional Feature:
- Macro: CASCADE_PERF_EN.
- Defined:
  - `feat_count` clears on the `start` that is accepted in IDLE.
  - It increments on each accepted `feat_valid` and saturates at all-ones.
  - It holds after `done`, reporting the features evaluated for the last window.
- Undefined: `feat_count` is tied to 0 and the counter logic is not built.

Test Plan:
- Reset then `start` with the evaluator returning +1 for every feature and `stage_thresh` = 0 -> all 22 stages pass. `feat_req` pulses 2135 times with `feat_gidx` 0..2134, then `done` = 1 and `face` = 1. With CASCADE_PERF_EN, `feat_count` = 2135.
- Stage 0 (3 features) returns -5 each, `stage_thresh` = 0 -> COMPARE fails, `done` with `face` = 0 and `stage_num` = 0. Exactly 3 requests issued (`feat_gidx` 0,1,2).
- Stages 0..1 pass, stage 2 fails -> `feat_gidx` of the first stage-2 request = 19. Rejection after 21 stage-2 features, `stage_num` = 2.
- `feat_amount` forced to -1 at stage 0 -> `done` pulse with `err` = 1, `face` = 0, and no `feat_req`.
- Saturation: `feat_value` = 0x7FFFFFFF for every feature -> `acc` clamps at 0x7FFFFFFF with no wrap negative, and the stage passes against `stage_thresh` = 0x7FFFFFFF.
- `Reset` pulsed while in WAIT during stage 5 -> next cycle state = IDLE with no `done`. A later `start` restarts from stage 0 with `feat_gidx` = 0. `start` and `feat_valid` pulsed while `busy` have no effect.
